alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 87 ++++++++
 tb/tb_alu_issue_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/write-back controller for a multi-cycle ALU owning the accumulator.
// Optional macro ALU_MUL_MASK_EN: zero the operand upper nibbles on MUL issue.
module alu_issue_ctrl #(
   parameter int LATENCY = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in_opcode,
   input  logic [7:0] in_data,
   input  logic       acc_clr,
   output logic [2:0] alu_opcode,
   output logic [7:0] alu_data,
   output logic [7:0] alu_accum,
   input  logic [7:0] alu_out,
   input  logic       alu_zero,
   output logic [7:0] accum,
   output logic       res_valid,
   output logic       res_zero,
   output logic       busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_WB   = 2'd2;

   localparam logic [2:0] LAT_LD = 3'(LATENCY);

   logic [1:0] state;
   logic [2:0] lat_cnt;
   logic [7:0] alu_data_q;
   logic       mul_mask;

   // Clear has priority over an offered instruction, so it also blocks acceptance.
   assign in_ready = (state == ST_IDLE) && !acc_clr;
   assign busy     = (state != ST_IDLE);

`ifdef ALU_MUL_MASK_EN
   assign mul_mask = (alu_opcode == 3'b110);
`else
   assign mul_mask = 1'b0;
`endif

   // The architectural accum stays unmasked; only the copy presented to the ALU is trimmed.
   assign alu_data  = mul_mask ? {4'h0, alu_data_q[3:0]} : alu_data_q;
   assign alu_accum = mul_mask ? {4'h0, accum[3:0]}      : accum;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         lat_cnt    <= 3'd0;
         accum      <= 8'h00;
         alu_opcode <= 3'd0;
         alu_data_q <= 8'h00;
         res_valid  <= 1'b0;
         res_zero   <= 1'b1;
      end else begin
         res_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (acc_clr) begin
                  accum    <= 8'h00;
                  res_zero <= 1'b1;
               end else if (in_valid) begin
                  alu_opcode <= in_opcode;
                  alu_data_q <= in_data;
                  lat_cnt    <= LAT_LD;
                  state      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               lat_cnt <= lat_cnt - 3'd1;
               if (lat_cnt == 3'd1) state <= ST_WB;
            end
            ST_WB: begin
               accum     <= alu_out;
               res_zero  <= alu_zero;
               res_valid <= 1'b1;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: LATENCY=1 and LATENCY=3 instances, each with a pipelined ALU model.
module tb_alu_issue_ctrl;

   localparam int L1 = 1;
   localparam int L3 = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic       in_valid1, in_ready1, acc_clr1, alu_zero1, res_valid1, res_zero1, busy1;
   logic [2:0] in_opcode1, alu_opcode1;
   logic [7:0] in_data1, alu_data1, alu_accum1, alu_out1, accum1;
   logic       in_valid3, in_ready3, acc_clr3, alu_zero3, res_valid3, res_zero3, busy3;
   logic [2:0] in_opcode3, alu_opcode3;
   logic [7:0] in_data3, alu_data3, alu_accum3, alu_out3, accum3;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] m_acc1, m_acc3;

   alu_issue_ctrl #(.LATENCY(L1)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_opcode(in_opcode1), .in_data(in_data1), .acc_clr(acc_clr1),
      .alu_opcode(alu_opcode1), .alu_data(alu_data1), .alu_accum(alu_accum1),
      .alu_out(alu_out1), .alu_zero(alu_zero1), .accum(accum1),
      .res_valid(res_valid1), .res_zero(res_zero1), .busy(busy1));

   alu_issue_ctrl #(.LATENCY(L3)) dut3 (
      .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
      .in_opcode(in_opcode3), .in_data(in_data3), .acc_clr(acc_clr3),
      .alu_opcode(alu_opcode3), .alu_data(alu_data3), .alu_accum(alu_accum3),
      .alu_out(alu_out3), .alu_zero(alu_zero3), .accum(accum3),
      .res_valid(res_valid3), .res_zero(res_zero3), .busy(busy3));

   function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d);
      logic [15:0] p;
      p = 16'(a) * 16'(d);
      case (op)
         3'd0: return a;
         3'd1: return a + d;
         3'd2: return a - d;
         3'd3: return a & d;
         3'd4: return a ^ d;
         3'd5: return d[7] ? 8'(0 - d) : d;
         3'd6: return p[7:0];
         default: return d;
      endcase
   endfunction

   function automatic logic [7:0] exp_data(input logic [2:0] op, input logic [7:0] d);
`ifdef ALU_MUL_MASK_EN
      if (op == 3'd6) return d & 8'h0F;
`endif
      return d;
   endfunction

   function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] acc, input logic [7:0] d);
      return alu_fn(op, exp_data(op, acc), exp_data(op, d));
   endfunction

   // External ALU: LATENCY register stages from the operands to alu_out.
   logic [7:0] pipe1;
   logic [7:0] pipe3 [3];
   always @(posedge clk) begin
      pipe1    <= alu_fn(alu_opcode1, alu_accum1, alu_data1);
      pipe3[0] <= alu_fn(alu_opcode3, alu_accum3, alu_data3);
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign alu_out1  = pipe1;
   assign alu_zero1 = (pipe1 == 8'h00);
   assign alu_out3  = pipe3[2];
   assign alu_zero3 = (pipe3[2] == 8'h00);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr1(input logic [2:0] op, input logic [7:0] d);
      logic [7:0] e;
      in_opcode1 = op; in_data1 = d; in_valid1 = 1'b1; acc_clr1 = 1'b0;
      #1;
      n_tests++;
      if (in_ready1 !== 1'b1) begin
         n_fail++; $display("FAIL accept_ready: in_ready=%b required 1", in_ready1);
      end
      tick();
      in_valid1 = 1'b0; in_data1 = ~d;
      e = ref_op(op, m_acc1, d);
      for (int c = 1; c <= L1 + 1; c++) begin
         #1;
         n_tests++;
         if (busy1 !== 1'b1 || res_valid1 !== 1'b0 || in_ready1 !== 1'b0 || alu_opcode1 !== op ||
             alu_data1 !== exp_data(op, d) || alu_accum1 !== exp_data(op, m_acc1)) begin
            n_fail++;
            $display("FAIL exec_hold cyc%0d: busy=%b rv=%b rdy=%b op=%h data=%h acc=%h required 1 0 0 %h %h %h",
                     c, busy1, res_valid1, in_ready1, alu_opcode1, alu_data1, alu_accum1,
                     op, exp_data(op, d), exp_data(op, m_acc1));
         end
         tick();
      end
      n_tests++;
      if (res_valid1 !== 1'b1 || accum1 !== e || res_zero1 !== (e == 8'h00) || busy1 !== 1'b0) begin
         n_fail++;
         $display("FAIL writeback op%0d d=%h: rv=%b accum=%h zero=%b busy=%b required 1 %h %b 0",
                  op, d, res_valid1, accum1, res_zero1, busy1, e, (e == 8'h00));
      end
      m_acc1 = e;
   endtask

   task automatic clear1(input logic with_valid);
      acc_clr1 = 1'b1; in_valid1 = with_valid; in_opcode1 = 3'd1; in_data1 = 8'h03;
      #1;
      n_tests++;
      if (in_ready1 !== 1'b0) begin
         n_fail++; $display("FAIL clr_ready: in_ready=%b required 0", in_ready1);
      end
      tick();
      acc_clr1 = 1'b0;
      m_acc1 = 8'h00;
      n_tests++;
      if (accum1 !== 8'h00 || res_zero1 !== 1'b1 || res_valid1 !== 1'b0 || busy1 !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_effect: accum=%h zero=%b rv=%b busy=%b required 00 1 0 0",
                  accum1, res_zero1, res_valid1, busy1);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid1 = 1'b0; acc_clr1 = 1'b0; in_opcode1 = 3'd0; in_data1 = 8'h00;
      in_valid3 = 1'b0; acc_clr3 = 1'b0; in_opcode3 = 3'd0; in_data3 = 8'h00;
      tick(); tick();
      n_tests++;
      if (accum1 !== 8'h00 || res_zero1 !== 1'b1 || res_valid1 !== 1'b0 || busy1 !== 1'b0 ||
          alu_opcode1 !== 3'd0 || alu_data1 !== 8'h00 || busy3 !== 1'b0 || accum3 !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_state: accum=%h zero=%b rv=%b busy=%b op=%h data=%h busy3=%b acc3=%h required 00 1 0 0 0 00 0 00",
                  accum1, res_zero1, res_valid1, busy1, alu_opcode1, alu_data1, busy3, accum3);
      end
      reset = 1'b0;
      m_acc1 = 8'h00; m_acc3 = 8'h00;
      tick();
   endtask

   task automatic test_passd();
      run_instr1(3'd7, 8'h13);
      n_tests++;
      if (accum1 !== 8'h13 || res_zero1 !== 1'b0) begin
         n_fail++; $display("FAIL passd_const: accum=%h zero=%b required 13 0", accum1, res_zero1);
      end
   endtask

   task automatic test_add_xor();
      clear1(1'b0);
      run_instr1(3'd1, 8'h05);
      run_instr1(3'd1, 8'h03);
      run_instr1(3'd4, 8'h08);
      n_tests++;
      if (accum1 !== 8'h00 || res_zero1 !== 1'b1) begin
         n_fail++; $display("FAIL add_xor_const: accum=%h zero=%b required 00 1", accum1, res_zero1);
      end
   endtask

   task automatic test_mul_mask();
      logic [7:0] want;
`ifdef ALU_MUL_MASK_EN
      want = 8'h0F;
`else
      want = 8'hBF;
`endif
      run_instr1(3'd7, 8'h13);
      run_instr1(3'd6, 8'h25);
      n_tests++;
      if (accum1 !== want) begin
         n_fail++; $display("FAIL mul_const: accum=%h required %h", accum1, want);
      end
   endtask

   task automatic test_clr_with_valid();
      run_instr1(3'd7, 8'h08);
      clear1(1'b1);
      run_instr1(3'd1, 8'h03);
   endtask

   task automatic test_reset_in_exec();
      run_instr1(3'd7, 8'h10);
      in_opcode1 = 3'd1; in_data1 = 8'h07; in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      n_tests++;
      if (busy1 !== 1'b1) begin
         n_fail++; $display("FAIL rst_exec_pre: busy=%b required 1", busy1);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_acc1 = 8'h00;
      n_tests++;
      if (busy1 !== 1'b0 || accum1 !== 8'h00 || res_zero1 !== 1'b1 || res_valid1 !== 1'b0 ||
          alu_opcode1 !== 3'd0 || alu_data1 !== 8'h00 || in_ready1 !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_exec: busy=%b accum=%h zero=%b rv=%b op=%h data=%h rdy=%b required 0 00 1 0 0 00 1",
                  busy1, accum1, res_zero1, res_valid1, alu_opcode1, alu_data1, in_ready1);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         n_tests++;
         if (res_valid1 !== 1'b0 || accum1 !== 8'h00) begin
            n_fail++; $display("FAIL rst_exec_after cyc%0d: rv=%b accum=%h required 0 00", c, res_valid1, accum1);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 7) == 0) clear1(1'($urandom_range(0, 1)));
         else run_instr1(3'($urandom_range(0, 7)), 8'($urandom));
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] op;
      logic [7:0] d;
      in_valid3 = 1'b1; acc_clr3 = 1'b0;
      for (int k = 0; k <= 6; k++) begin
         op = 3'($urandom_range(1, 7)); d = 8'($urandom);
         in_opcode3 = op; in_data3 = d;
         #1;
         n_tests++;
         if (in_ready3 !== 1'b1 || busy3 !== 1'b0 || res_valid3 !== (k > 0) || accum3 !== m_acc3 ||
             res_zero3 !== (m_acc3 == 8'h00)) begin
            n_fail++;
            $display("FAIL b2b_accept k%0d: rdy=%b busy=%b rv=%b accum=%h zero=%b required 1 0 %b %h %b",
                     k, in_ready3, busy3, res_valid3, accum3, res_zero3, (k > 0), m_acc3, (m_acc3 == 8'h00));
         end
         if (k == 6) break;
         tick();
         in_data3 = ~d;
         for (int c = 1; c <= L3 + 1; c++) begin
            #1;
            n_tests++;
            if (in_ready3 !== 1'b0 || busy3 !== 1'b1 || res_valid3 !== 1'b0 || alu_data3 !== exp_data(op, d)) begin
               n_fail++;
               $display("FAIL b2b_busy k%0d c%0d: rdy=%b busy=%b rv=%b data=%h required 0 1 0 %h",
                        k, c, in_ready3, busy3, res_valid3, alu_data3, exp_data(op, d));
            end
            tick();
         end
         m_acc3 = ref_op(op, m_acc3, d);
      end
      in_valid3 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_passd();
      test_add_xor();
      test_mul_mask();
      test_clr_with_valid();
      test_reset_in_exec();
      test_random();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
